// File: rtl/cg_pkg.sv
// Shared definitions for the burst clock-gate sequencer: state encoding and
// default counter widths.
package cg_pkg;

  localparam int CNT_WIDTH_DEF  = 16;
  localparam int REP_WIDTH_DEF  = 8;
  localparam int PCNT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/CG_MOD_pos.sv
// Latch-based clock gate for a positive-edge domain: the enable is captured
// while ck_in is low, so ck_out can only change together with ck_in rising.
module CG_MOD_pos (
  input  logic ck_in,
  input  logic enable,
  output logic ck_out
);

  logic r_en_lat;

  always_latch begin
    if (!ck_in) r_en_lat <= enable;
  end

  assign ck_out = ck_in & r_en_lat;

endmodule

// File: rtl/cg_burst_ctrl.sv
// Burst sequencer driving the enable of a single clock gate: start delay,
// burst width, inter-burst gap and repeat count, plus force-on and pulse count.
module cg_burst_ctrl
  import cg_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int REP_WIDTH  = REP_WIDTH_DEF,
  parameter int PCNT_WIDTH = PCNT_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  FORCE_ON,
  input  logic [CNT_WIDTH-1:0]  CONF_DELAY,
  input  logic [CNT_WIDTH-1:0]  CONF_WIDTH,
  input  logic [CNT_WIDTH-1:0]  CONF_GAP,
  input  logic [REP_WIDTH-1:0]  CONF_REPEAT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  CG_EN,
  output logic                  CK_OUT,
  output logic [PCNT_WIDTH-1:0] PULSE_CNT
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [REP_WIDTH-1:0]  REP_ONE  = REP_WIDTH'(1);
  localparam logic [PCNT_WIDTH-1:0] PCNT_MAX = '1;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, r_width, r_gap;
  logic [REP_WIDTH-1:0]  r_rep_left;
  logic                  r_rep_inf;
  logic [PCNT_WIDTH-1:0] r_pcnt;
  logic                  r_cg_en, r_busy, r_done;
  logic                  w_accept, w_cnt_zero, w_last_burst;
  logic                  w_cg_en_d, w_busy_d, w_done_d;

  function automatic logic [PCNT_WIDTH-1:0] sat_inc(input logic [PCNT_WIDTH-1:0] v);
    return (v == PCNT_MAX) ? v : v + 1'b1;
  endfunction

  assign w_accept     = (r_state == IDLE) && START && !STOP;
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_last_burst = !r_rep_inf && (r_rep_left == REP_ONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cg_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cg_en <= w_cg_en_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (CONF_DELAY != '0)      w_state_nxt = DELAY;
          else if (CONF_WIDTH != '0) w_state_nxt = RUN;
        end
      end
      DELAY: begin
        if (STOP)            w_state_nxt = IDLE;
        else if (w_cnt_zero) w_state_nxt = (r_width != '0) ? RUN : IDLE;
      end
      RUN: begin
        if (STOP) w_state_nxt = IDLE;
        else if (w_cnt_zero) begin
          if (w_last_burst)      w_state_nxt = IDLE;
          else if (r_gap != '0)  w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (STOP)            w_state_nxt = IDLE;
        else if (w_cnt_zero) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with CG_EN.
  always_comb begin
    w_cg_en_d = (w_state_nxt == RUN) || FORCE_ON;
    w_busy_d  = (w_state_nxt != IDLE);
    w_done_d  = 1'b0;
    case (r_state)
      IDLE:    w_done_d = w_accept && (CONF_DELAY == '0) && (CONF_WIDTH == '0);
      DELAY:   w_done_d = !STOP && w_cnt_zero && (r_width == '0);
      RUN:     w_done_d = !STOP && w_cnt_zero && w_last_burst;
      default: w_done_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_width    <= '0;
      r_gap      <= '0;
      r_rep_left <= '0;
      r_rep_inf  <= 1'b0;
      r_pcnt     <= '0;
    end else begin
      if (w_accept) begin
        r_width    <= CONF_WIDTH;
        r_gap      <= CONF_GAP;
        r_rep_left <= CONF_REPEAT;
        r_rep_inf  <= (CONF_REPEAT == '0);
        r_pcnt     <= '0;
      end else if (r_state == RUN) begin
        r_pcnt <= sat_inc(r_pcnt);
        if (w_cnt_zero && !r_rep_inf) r_rep_left <= r_rep_left - REP_ONE;
      end

      // Counters hold value-1 on entry so the terminal cycle is cnt==0.
      if (w_state_nxt == IDLE) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          IDLE:        r_cnt <= (CONF_DELAY != '0) ? CONF_DELAY - CNT_ONE : CONF_WIDTH - CNT_ONE;
          DELAY, GAP:  r_cnt <= w_cnt_zero ? r_width - CNT_ONE : r_cnt - CNT_ONE;
          RUN:         r_cnt <= !w_cnt_zero    ? r_cnt - CNT_ONE :
                                (r_gap != '0)  ? r_gap - CNT_ONE : r_width - CNT_ONE;
          default:     r_cnt <= '0;
        endcase
      end
    end
  end

  CG_MOD_pos u_cg (
    .ck_in  (CLK),
    .enable (r_cg_en),
    .ck_out (CK_OUT)
  );

  assign CG_EN     = r_cg_en;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PULSE_CNT = r_pcnt;

endmodule

// File: tb/tb_cg_burst_ctrl.sv
// Bench for cg_burst_ctrl: directed and random steps checked every cycle
// against an arithmetic model of the burst timing.
module tb_cg_burst_ctrl;

  localparam int CW   = 10;
  localparam int RW   = 8;
  localparam int PW   = 6;
  localparam int PMAX = (1 << PW) - 1;

  logic          CLK = 1'b0;
  logic          RST, START, STOP, FORCE_ON;
  logic [CW-1:0] CONF_DELAY, CONF_WIDTH, CONF_GAP;
  logic [RW-1:0] CONF_REPEAT;
  logic          BUSY, DONE, CG_EN, CK_OUT;
  logic [PW-1:0] PULSE_CNT;

  int n_vec = 0;
  int n_fail = 0;

  // model of the sequence in flight
  bit     m_act, m_force_prev;
  int     m_t, m_d, m_w, m_g, m_rep, m_stop, m_pcnt, m_ck, cyc;
  int     ck_cnt, base;
  bit     mon_en = 1'b0;
  bit     rise_ok = 1'b0;
  longint t_rise;
  bit     last_cg, last_busy, last_done;
  logic [15:0] pat_cg, pat_busy, pat_done;

  always #5 CLK = ~CLK;

  cg_burst_ctrl #(.CNT_WIDTH(CW), .REP_WIDTH(RW), .PCNT_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .FORCE_ON(FORCE_ON),
    .CONF_DELAY(CONF_DELAY), .CONF_WIDTH(CONF_WIDTH), .CONF_GAP(CONF_GAP),
    .CONF_REPEAT(CONF_REPEAT), .BUSY(BUSY), .DONE(DONE), .CG_EN(CG_EN),
    .CK_OUT(CK_OUT), .PULSE_CNT(PULSE_CNT)
  );

  always @(posedge CK_OUT) begin
    if (mon_en) begin
      ck_cnt++;
      t_rise  = $time;
      rise_ok = 1'b1;
    end
  end

  always @(negedge CK_OUT) begin
    if (mon_en && rise_ok) begin
      n_vec++;
      assert ($time - t_rise >= 5) else begin
        n_fail++;
        $error("FAIL CK_OUT_WIDTH: observed high %0d required >= 5", $time - t_rise);
      end
      rise_ok = 1'b0;
    end
  end

  function automatic int seq_len();
    if (m_w == 0)   return m_d;
    if (m_rep == 0) return 32'h3fffffff;
    return m_d + m_rep * m_w + (m_rep - 1) * m_g;
  endfunction

  function automatic bit m_alive(int c);
    return m_act && (m_stop < 0 || c <= m_stop);
  endfunction

  function automatic bit m_busy(int c);
    return m_alive(c) && c >= m_t + 1 && c <= m_t + seq_len();
  endfunction

  function automatic bit m_run(int c);
    int rel, per;
    if (!m_alive(c) || m_w == 0) return 1'b0;
    rel = c - (m_t + 1 + m_d);
    if (rel < 0) return 1'b0;
    per = m_w + m_g;
    return (rel % per < m_w) && (m_rep == 0 || rel / per < m_rep);
  endfunction

  function automatic bit m_done(int c);
    return m_act && m_stop < 0 && c == m_t + seq_len() + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    bit run, e_cg, acc;
    @(negedge CLK);
    run  = m_run(cyc);
    e_cg = run | m_force_prev;
    last_cg = CG_EN; last_busy = BUSY; last_done = DONE;
    check("CG_EN", 64'(CG_EN), 64'(e_cg));
    check("BUSY", 64'(BUSY), 64'(m_busy(cyc)));
    check("DONE", 64'(DONE), 64'(m_done(cyc)));
    check("PULSE_CNT", 64'(PULSE_CNT), 64'(m_pcnt));
    check("CK_PULSES", 64'(ck_cnt), 64'(m_ck));
    m_ck += int'(e_cg);
    if (RST) begin
      m_act = 1'b0; m_pcnt = 0; m_force_prev = 1'b0;
    end else begin
      acc = !m_busy(cyc) && START && !STOP;
      if (STOP && m_busy(cyc)) m_stop = cyc;
      if (acc) begin
        m_act = 1'b1; m_t = cyc; m_stop = -1; m_pcnt = 0;
        m_d = int'(CONF_DELAY); m_w = int'(CONF_WIDTH);
        m_g = int'(CONF_GAP);   m_rep = int'(CONF_REPEAT);
      end else if (run && m_pcnt < PMAX) begin
        m_pcnt++;
      end
      m_force_prev = FORCE_ON;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_n(input int n);
    repeat (n) tick();
  endtask

  task automatic grab(input int n);
    pat_cg = '0; pat_busy = '0; pat_done = '0;
    repeat (n) begin
      tick();
      pat_cg   = {pat_cg[14:0], last_cg};
      pat_busy = {pat_busy[14:0], last_busy};
      pat_done = {pat_done[14:0], last_done};
    end
  endtask

  task automatic set_conf(input int d, input int w, input int g, input int rep);
    CONF_DELAY = CW'(d); CONF_WIDTH = CW'(w); CONF_GAP = CW'(g); CONF_REPEAT = RW'(rep);
  endtask

  task automatic start_seq(input int d, input int w, input int g, input int rep);
    set_conf(d, w, g, rep);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; STOP = 1'b0; FORCE_ON = 1'b0;
    set_conf(0, 0, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    cyc = 0; m_act = 1'b0; m_pcnt = 0; m_force_prev = 1'b0; m_ck = 0; m_stop = -1;
    ck_cnt = 0; mon_en = 1'b1;
    tick();
    RST = 1'b0;
    run_n(3);

    // basic burst
    base = ck_cnt;
    start_seq(3, 5, 0, 1);
    grab(9);
    check("BASIC_CG", 64'(pat_cg[8:0]), 64'(9'b000111110));
    check("BASIC_BUSY", 64'(pat_busy[8:0]), 64'(9'b111111110));
    check("BASIC_DONE", 64'(pat_done[8:0]), 64'(9'b000000001));
    run_n(2);
    check("BASIC_PULSES", 64'(ck_cnt - base), 64'd5);
    check("BASIC_PCNT", 64'(PULSE_CNT), 64'd5);

    // repeated bursts with gap
    base = ck_cnt;
    start_seq(0, 2, 3, 3);
    grab(14);
    check("REP_CG", 64'(pat_cg[13:0]), 64'(14'b11000110001100));
    check("REP_DONE", 64'(pat_done[13:0]), 64'(14'b00000000000010));
    run_n(3);
    check("REP_PULSES", 64'(ck_cnt - base), 64'd6);
    check("REP_PCNT", 64'(PULSE_CNT), 64'd6);

    // zero width, with and without delay
    base = ck_cnt;
    start_seq(2, 0, 0, 1);
    grab(4);
    check("W0_BUSY", 64'(pat_busy[3:0]), 64'(4'b1100));
    check("W0_DONE", 64'(pat_done[3:0]), 64'(4'b0010));
    start_seq(0, 0, 0, 1);
    grab(2);
    check("W0D0_DONE", 64'(pat_done[1:0]), 64'(2'b10));
    check("W0_PULSES", 64'(ck_cnt - base), 64'd0);

    // zero gap: contiguous bursts
    base = ck_cnt;
    start_seq(0, 4, 0, 2);
    grab(10);
    check("G0_CG", 64'(pat_cg[9:0]), 64'(10'b1111111100));
    run_n(2);
    check("G0_PULSES", 64'(ck_cnt - base), 64'd8);

    // abort of an endless sequence
    base = ck_cnt;
    start_seq(0, 3, 1, 0);
    run_n(20);
    STOP = 1'b1; tick(); STOP = 1'b0;
    run_n(3);
    check("ABORT_PCNT", 64'(PULSE_CNT), 64'(ck_cnt - base));

    // START and STOP together in IDLE
    set_conf(0, 2, 0, 1);
    START = 1'b1; STOP = 1'b1; tick(); START = 1'b0; STOP = 1'b0;
    grab(3);
    check("SS_BUSY", 64'(pat_busy[2:0]), 64'd0);

    // START while busy is ignored
    base = ck_cnt;
    start_seq(2, 3, 0, 1);
    tick();
    start_seq(0, 1, 0, 1);
    run_n(8);
    check("BUSYSTART_PULSES", 64'(ck_cnt - base), 64'd3);

    // START in the DONE cycle
    base = ck_cnt;
    start_seq(1, 2, 0, 1);
    run_n(3);
    check("DONE_CYCLE", 64'(DONE), 64'd1);
    start_seq(0, 3, 0, 1);
    run_n(5);
    check("DONESTART_PULSES", 64'(ck_cnt - base), 64'd5);

    // reset mid-RUN
    start_seq(0, 5, 0, 1);
    run_n(2);
    RST = 1'b1; tick(); RST = 1'b0;
    check("RST_BUSY", 64'(BUSY), 64'd0);
    check("RST_CG_EN", 64'(CG_EN), 64'd0);
    check("RST_PCNT", 64'(PULSE_CNT), 64'd0);
    run_n(3);

    // force-on then a short sequence
    base = ck_cnt;
    FORCE_ON = 1'b1; run_n(10); FORCE_ON = 1'b0;
    start_seq(0, 2, 0, 1);
    run_n(5);
    check("FORCE_PULSES", 64'(ck_cnt - base), 64'd12);
    check("FORCE_PCNT", 64'(PULSE_CNT), 64'd2);

    // maximum width and delay, long repeat, counter saturation
    base = ck_cnt;
    start_seq(0, (1 << CW) - 1, 0, 1);
    run_n((1 << CW) + 3);
    check("MAXW_PULSES", 64'(ck_cnt - base), 64'((1 << CW) - 1));
    check("MAXW_PCNT_SAT", 64'(PULSE_CNT), 64'(PMAX));
    start_seq((1 << CW) - 1, 1, 0, 1);
    run_n((1 << CW) + 3);
    base = ck_cnt;
    start_seq(0, 1, 0, 255);
    run_n(260);
    check("REP255_PULSES", 64'(ck_cnt - base), 64'd255);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      START    = ($urandom % 6) == 0;
      STOP     = ($urandom % 25) == 0;
      FORCE_ON = ($urandom % 15) == 0;
      RST      = ($urandom % 300) == 0;
      set_conf(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      tick();
    end
    START = 1'b0; FORCE_ON = 1'b0; RST = 1'b0;
    STOP = 1'b1; tick(); STOP = 1'b0;
    run_n(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
